seg7_capture_decoder: RTL

Receive-side counterpart of the team's seg7 digit-to-segment encoder. Samples a multiplexed 7-segment bus (segment lines plus one-hot digit enables), waits for each pattern to settle, decodes it back to a 4-bit hex value and stores it per digit position. It sits at the chip input pins and lets the design read back a display driven by another board, or loop-test our own seg7 output.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_capture_decoder_if.sv | 35 +++
 rtl/seg7_pattern_decode.sv | 24 ++
 rtl/seg7_capture_decoder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 display blocks.
//   SEG_W        : width of a segment pattern (bit0=a .. bit6=g)
//   SEG_PATTERN  : hex digit -> active-high segment pattern; the encoder
//                  and the capture decoder both index this one table
//   cap_state_e  : capture FSM states
//   seg7_encode  : digit -> pattern lookup used by the encoder
//   count_ones   : population count of up to 8 digit strobes
package seg7_pkg;

    localparam int SEG_W = 7;

    // Index 0 is the leftmost element of the concatenation.
    localparam logic [0:15][SEG_W-1:0] SEG_PATTERN = {
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HOLD  = 2'd2
    } cap_state_e;

    function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] value);
        return SEG_PATTERN[value];
    endfunction

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/seg7_capture_decoder_if.sv
// Bus bundle between the pin-side seg7 display lines and the capture decoder.
//   seg_in      : segment lines, bit0=a .. bit6=g (driven by master)
//   dig_en      : digit strobes, one-hot when valid (driven by master)
//   digit_value : captured hex values, digit i at [4i+3:4i] (driven by slave)
//   digit_valid : digit i holds a legally decoded value (slave)
//   upd_pulse   : one-cycle pulse per successful capture (slave)
//   upd_index   : digit index of the last capture (slave)
//   err_invalid : one-cycle pulse, stable pattern not a hex digit (slave)
//   err_multi   : one-cycle pulse, stable strobe with several bits set (slave)
interface seg7_capture_decoder_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    logic [SEG_W-1:0]        seg_in;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic [4*NUM_DIGITS-1:0] digit_value;
    logic [NUM_DIGITS-1:0]   digit_valid;
    logic                    upd_pulse;
    logic [2:0]              upd_index;
    logic                    err_invalid;
    logic                    err_multi;

    modport master (
        output seg_in, dig_en,
        input  digit_value, digit_valid, upd_pulse, upd_index,
               err_invalid, err_multi
    );

    modport slave (
        input  seg_in, dig_en,
        output digit_value, digit_valid, upd_pulse, upd_index,
               err_invalid, err_multi
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seg7 encoder.
//   pattern : active-high segment pattern (bit0=a .. bit6=g)
//   value   : hex digit whose pattern matches (0 when no match)
//   valid   : 1 when pattern is one of the 16 table entries
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [3:0]       value,
    output logic             valid
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERN[i]) begin
                value = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed 7-segment bus, waits for it to settle, decodes the
// pattern back to a hex value and stores it per digit position.
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of seg7_capture_decoder_if (pins in, results out)
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_capture_decoder_if.slave  bus
);

    localparam int VEC_W = SEG_W + NUM_DIGITS;
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [VEC_W-1:0]        pin_vec;
    logic [VEC_W-1:0]        sync1_q, sync1_d;
    logic [VEC_W-1:0]        sync2_q, sync2_d;
    logic [VEC_W-1:0]        samp_q, samp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    cap_state_e              state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digit_value_q, digit_value_d;
    logic [NUM_DIGITS-1:0]   digit_valid_q, digit_valid_d;
    logic                    upd_pulse_q, upd_pulse_d;
    logic [2:0]              upd_index_q, upd_index_d;
    logic                    err_invalid_q, err_invalid_d;
    logic                    err_multi_q, err_multi_d;

    logic                    changed;
    logic [NUM_DIGITS-1:0]   samp_dig;
    logic [3:0]              ones;
    logic [3:0]              dec_value;
    logic                    dec_ok;

    // Polarity is normalised at the pins so everything downstream is active-high.
    assign pin_vec = (ACTIVE_LOW != 0) ? ~{bus.dig_en, bus.seg_in}
                                       :  {bus.dig_en, bus.seg_in};

    assign samp_dig = samp_q[VEC_W-1:SEG_W];
    assign ones     = count_ones(8'(samp_dig));

    seg7_pattern_decode u_decode (
        .pattern (samp_q[SEG_W-1:0]),
        .value   (dec_value),
        .valid   (dec_ok)
    );

    // Synchronizer, sample register and saturating stability counter.
    always_comb begin
        sync1_d = pin_vec;
        sync2_d = sync1_q;
        samp_d  = sync2_q;
        changed = (sync2_q != samp_q);
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // FSM and digit register bank. CHECK is entered on the edge where the
    // counter reaches its limit, so the event lands one edge later.
    always_comb begin
        state_d       = state_q;
        digit_value_d = digit_value_q;
        digit_valid_d = digit_valid_q;
        upd_pulse_d   = 1'b0;
        upd_index_d   = upd_index_q;
        err_invalid_d = 1'b0;
        err_multi_d   = 1'b0;

        unique case (state_q)
            ST_WAIT: begin
                if (!changed && cnt_d == CNT_MAX) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_HOLD;
                if (ones > 4'd1) begin
                    err_multi_d = 1'b1;
                end else begin
                    // At most one strobe is set here; all-zero is blanking.
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (samp_dig[i]) begin
                            if (dec_ok) begin
                                digit_value_d[4*i +: 4] = dec_value;
                                digit_valid_d[i]        = 1'b1;
                                upd_pulse_d             = 1'b1;
                                upd_index_d             = 3'(i);
                            end else begin
                                digit_valid_d[i] = 1'b0;
                                err_invalid_d    = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                // A counter below its limit means the vector moved while in
                // CHECK; that change must still release the hold.
                if (changed || cnt_q != CNT_MAX) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            samp_q        <= '0;
            cnt_q         <= '0;
            state_q       <= ST_WAIT;
            digit_value_q <= '0;
            digit_valid_q <= '0;
            upd_pulse_q   <= 1'b0;
            upd_index_q   <= '0;
            err_invalid_q <= 1'b0;
            err_multi_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            samp_q        <= samp_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            digit_value_q <= digit_value_d;
            digit_valid_q <= digit_valid_d;
            upd_pulse_q   <= upd_pulse_d;
            upd_index_q   <= upd_index_d;
            err_invalid_q <= err_invalid_d;
            err_multi_q   <= err_multi_d;
        end
    end

    assign bus.digit_value = digit_value_q;
    assign bus.digit_valid = digit_valid_q;
    assign bus.upd_pulse   = upd_pulse_q;
    assign bus.upd_index   = upd_index_q;
    assign bus.err_invalid = err_invalid_q;
    assign bus.err_multi   = err_multi_q;

endmodule
